mbit_multi_prio_merge: RTL and testbench

MBIT_MULTI_PRIO_MERGE -- requirements
Module: mbit_multi_prio_merge

---
 rtl/mbit_multi_prio_merge.sv | 161 ++++++++++++++++
 tb/tb_mbit_multi_prio_merge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mbit_multi_prio_merge.sv
// mbit_multi_prio_merge: per-lane merge of NUM_PIPES classification results.
// Stage 1 registers every input bit. Stage 2 picks, per lane, the hitting
// pipe with the lowest rule id (ties go to the lowest pipe index) and
// registers the result. The total latency is 2 cycles, with no stalls.
// Optional build macro MBIT_MERGE_STATS_EN adds per-lane saturating hit/miss
// counters, read combinationally through stat_sel. Without the macro,
// hit_cnt and miss_cnt are tied to 0 and no counter flops exist.
// Interfaces carry no handshake. Each valid bit qualifies its data in the
// same cycle, and the block accepts one packet per lane every cycle.
module mbit_multi_prio_merge #(
  parameter int                NUM_PORTS    = 2,
  parameter int                NUM_PIPES    = 4,
  parameter int                RULE_ID      = 14,
  parameter logic [RULE_ID-1:0] DEFAULT_RULE = '1,
  parameter int                CNT_W        = 32,
  localparam int               PIPE_W       = $clog2(NUM_PIPES),
  localparam int               SEL_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              RST,
  input  logic [NUM_PORTS*NUM_PIPES*RULE_ID-1:0] rule_in,
  input  logic [NUM_PORTS*NUM_PIPES-1:0]    data_valid_in,
  input  logic [NUM_PORTS*NUM_PIPES-1:0]    act_valid_in,
  input  logic                              err_clr,
  input  logic [SEL_W-1:0]                  stat_sel,
  output logic [NUM_PORTS*RULE_ID-1:0]      rule_id,
  output logic [NUM_PORTS-1:0]              data_valid_out,
  output logic [NUM_PORTS-1:0]              action_valid,
  output logic [NUM_PORTS*PIPE_W-1:0]       win_pipe,
  output logic                              align_err,
  output logic [CNT_W-1:0]                  hit_cnt,
  output logic [CNT_W-1:0]                  miss_cnt
);

  localparam int NP = NUM_PIPES;

  // Stage 1 registers
  logic [NUM_PORTS*NP*RULE_ID-1:0] s1_rule;
  logic [NUM_PORTS*NP-1:0]         s1_dv;
  logic [NUM_PORTS*NP-1:0]         s1_av;

  // Stage 2 next-state values
  logic [NUM_PORTS*RULE_ID-1:0]    nxt_rule;
  logic [NUM_PORTS-1:0]            nxt_dv;
  logic [NUM_PORTS-1:0]            nxt_av;
  logic [NUM_PORTS*PIPE_W-1:0]     nxt_win;
  logic [NUM_PORTS-1:0]            lane_mis;

  // Per-lane scratch values used by the winner search
  logic                            found;
  logic [RULE_ID-1:0]              best_id;
  logic [PIPE_W-1:0]               best_idx;

  // Stage 1: capture all inputs every cycle, unconditionally
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_rule <= '0;
      s1_dv   <= '0;
      s1_av   <= '0;
    end else begin
      s1_rule <= rule_in;
      s1_dv   <= data_valid_in;
      s1_av   <= act_valid_in;
    end
  end

  // Winner search and output shaping. The packet-valid of a lane is taken
  // from pipe 0. Hits are honoured only on a valid packet. A miss drives
  // DEFAULT_RULE. An invalid lane drives all zeros.
  always_comb begin
    nxt_rule = '0;
    nxt_dv   = '0;
    nxt_av   = '0;
    nxt_win  = '0;
    lane_mis = '0;
    found    = 1'b0;
    best_id  = '0;
    best_idx = '0;
    for (int l = 0; l < NUM_PORTS; l++) begin
      found    = 1'b0;
      best_id  = '0;
      best_idx = '0;
      // A strict less-than keeps the earlier, lower-index pipe on equal ids.
      for (int p = 0; p < NP; p++) begin
        if (s1_av[l*NP+p] &&
            (!found || (s1_rule[(l*NP+p)*RULE_ID +: RULE_ID] < best_id))) begin
          found    = 1'b1;
          best_id  = s1_rule[(l*NP+p)*RULE_ID +: RULE_ID];
          best_idx = PIPE_W'(p);
        end
      end
      lane_mis[l] = (|s1_dv[l*NP +: NP]) && !(&s1_dv[l*NP +: NP]);
      if (s1_dv[l*NP]) begin
        nxt_dv[l] = 1'b1;
        if (found) begin
          nxt_av[l]                        = 1'b1;
          nxt_rule[l*RULE_ID +: RULE_ID]   = best_id;
          nxt_win[l*PIPE_W +: PIPE_W]      = best_idx;
        end else begin
          nxt_rule[l*RULE_ID +: RULE_ID]   = DEFAULT_RULE;
        end
      end
    end
  end

  // Stage 2: register the merged result. align_err is sticky. When a new
  // misalignment and err_clr arrive in the same cycle, the set wins.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rule_id        <= '0;
      data_valid_out <= '0;
      action_valid   <= '0;
      win_pipe       <= '0;
      align_err      <= 1'b0;
    end else begin
      rule_id        <= nxt_rule;
      data_valid_out <= nxt_dv;
      action_valid   <= nxt_av;
      win_pipe       <= nxt_win;
      align_err      <= (align_err & ~err_clr) | (|lane_mis);
    end
  end

`ifdef MBIT_MERGE_STATS_EN
  logic [CNT_W-1:0] hit_q  [NUM_PORTS];
  logic [CNT_W-1:0] miss_q [NUM_PORTS];

  // Saturating per-lane counters that advance alongside the stage-2 load
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int l = 0; l < NUM_PORTS; l++) begin
        hit_q[l]  <= '0;
        miss_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_PORTS; l++) begin
        if (nxt_av[l] && (hit_q[l] != '1))
          hit_q[l] <= hit_q[l] + CNT_W'(1);
        if (nxt_dv[l] && !nxt_av[l] && (miss_q[l] != '1))
          miss_q[l] <= miss_q[l] + CNT_W'(1);
      end
    end
  end

  // Combinational statistics read of the selected lane
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    if (int'(stat_sel) < NUM_PORTS) begin
      hit_cnt  = hit_q[stat_sel];
      miss_cnt = miss_q[stat_sel];
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign hit_cnt         = '0;
  assign miss_cnt        = '0;
`endif

endmodule

// File: tb/tb_mbit_multi_prio_merge.sv
// Directed, table-driven bench for mbit_multi_prio_merge (2 lanes, 4 pipes).
module tb_mbit_multi_prio_merge;

  localparam int NPORT = 2;
  localparam int NPIPE = 4;
  localparam int RW    = 14;
  localparam int CW    = 4;

  logic                       clk;
  logic                       RST;
  logic [NPORT*NPIPE*RW-1:0]  rule_in;
  logic [NPORT*NPIPE-1:0]     data_valid_in;
  logic [NPORT*NPIPE-1:0]     act_valid_in;
  logic                       err_clr;
  logic [0:0]                 stat_sel;
  logic [NPORT*RW-1:0]        rule_id;
  logic [NPORT-1:0]           data_valid_out;
  logic [NPORT-1:0]           action_valid;
  logic [NPORT*2-1:0]         win_pipe;
  logic                       align_err;
  logic [CW-1:0]              hit_cnt;
  logic [CW-1:0]              miss_cnt;

  int tests;
  int fails;

  typedef struct {
    logic [NPORT*NPIPE*RW-1:0] rule;
    logic [7:0]                dv;
    logic [7:0]                av;
    logic [27:0]               e_rule;
    logic [1:0]                e_dv;
    logic [1:0]                e_av;
    logic [3:0]                e_win;
  } vec_t;

  vec_t vec[5];
  int   pat[3];

  mbit_multi_prio_merge #(
    .NUM_PORTS(NPORT), .NUM_PIPES(NPIPE), .RULE_ID(RW), .CNT_W(CW)
  ) dut (
    .clk(clk), .RST(RST), .rule_in(rule_in), .data_valid_in(data_valid_in),
    .act_valid_in(act_valid_in), .err_clr(err_clr), .stat_sel(stat_sel),
    .rule_id(rule_id), .data_valid_out(data_valid_out),
    .action_valid(action_valid), .win_pipe(win_pipe), .align_err(align_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NPORT*NPIPE*RW-1:0] put(
      input logic [NPORT*NPIPE*RW-1:0] r, input int lane, input int pipe,
      input logic [RW-1:0] id);
    logic [NPORT*NPIPE*RW-1:0] t;
    t = r;
    t[(lane*NPIPE+pipe)*RW +: RW] = id;
    return t;
  endfunction

  function automatic logic [35:0] exp_of(input int k);
    if (k < 0) return '0;
    return {vec[k].e_rule, vec[k].e_dv, vec[k].e_av, vec[k].e_win};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    rule_in       = vec[k].rule;
    data_valid_in = vec[k].dv;
    act_valid_in  = vec[k].av;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {rule_id, data_valid_out, action_valid, win_pipe};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    pat[0] = 0; pat[1] = 1; pat[2] = 3;

    // V0: lane0 hits pipes 1,3 (0x120, 0x045); lane1 hits pipes 1,2
    vec[0].rule = '0;
    vec[0].rule = put(vec[0].rule, 0, 0, 14'h001);
    vec[0].rule = put(vec[0].rule, 0, 1, 14'h120);
    vec[0].rule = put(vec[0].rule, 0, 3, 14'h045);
    vec[0].rule = put(vec[0].rule, 1, 1, 14'h0AB);
    vec[0].rule = put(vec[0].rule, 1, 2, 14'h0AC);
    vec[0].rule = put(vec[0].rule, 1, 3, 14'h002);
    vec[0].dv = 8'hFF; vec[0].av = 8'h6A;
    vec[0].e_rule = {14'h0AB, 14'h045}; vec[0].e_dv = 2'b11;
    vec[0].e_av = 2'b11; vec[0].e_win = {2'd1, 2'd3};
    // V1: lane0 tie on 0x010 at pipes 0,2; lane1 valid with no hit
    vec[1].rule = '0;
    vec[1].rule = put(vec[1].rule, 0, 0, 14'h010);
    vec[1].rule = put(vec[1].rule, 0, 1, 14'h005);
    vec[1].rule = put(vec[1].rule, 0, 2, 14'h010);
    vec[1].dv = 8'hFF; vec[1].av = 8'h05;
    vec[1].e_rule = {14'h3FFF, 14'h010}; vec[1].e_dv = 2'b11;
    vec[1].e_av = 2'b01; vec[1].e_win = {2'd0, 2'd0};
    // V2: lane0 hits but not valid; lane1 tie on 0x100 at pipes 2,3
    vec[2].rule = '0;
    for (int p = 0; p < 4; p++) vec[2].rule = put(vec[2].rule, 0, p, 14'h007);
    vec[2].rule = put(vec[2].rule, 1, 0, 14'h300);
    vec[2].rule = put(vec[2].rule, 1, 1, 14'h200);
    vec[2].rule = put(vec[2].rule, 1, 2, 14'h100);
    vec[2].rule = put(vec[2].rule, 1, 3, 14'h100);
    vec[2].dv = 8'hF0; vec[2].av = 8'hFF;
    vec[2].e_rule = {14'h100, 14'h000}; vec[2].e_dv = 2'b10;
    vec[2].e_av = 2'b10; vec[2].e_win = {2'd2, 2'd0};
    // V3: lane0 single hit at pipe 3 with max id; lane1 hit id 0 at pipe 0
    vec[3].rule = '0;
    vec[3].rule = put(vec[3].rule, 0, 3, 14'h3FFF);
    vec[3].rule = put(vec[3].rule, 1, 1, 14'h001);
    vec[3].dv = 8'hFF; vec[3].av = 8'h18;
    vec[3].e_rule = {14'h000, 14'h3FFF}; vec[3].e_dv = 2'b11;
    vec[3].e_av = 2'b11; vec[3].e_win = {2'd0, 2'd3};
    // V4: idle
    vec[4].rule = '0; vec[4].dv = 8'h00; vec[4].av = 8'h00;
    vec[4].e_rule = '0; vec[4].e_dv = '0; vec[4].e_av = '0; vec[4].e_win = '0;

    // Reset
    RST = 1'b1; err_clr = 1'b0; stat_sel = 1'b0;
    rule_in = '0; data_valid_in = '0; act_valid_in = '0;
    tick(); tick();
    check("reset_outputs", 64'(outs()), 64'd0);
    check("reset_align_err", 64'(align_err), 64'd0);
    check("reset_hit_cnt", 64'(hit_cnt), 64'd0);
    check("reset_miss_cnt", 64'(miss_cnt), 64'd0);
    RST = 1'b0;
    tick();

    // Table: apply each vector, hold it, check after two edges
    for (int i = 0; i < 5; i++) begin
      drive(i);
      tick(); tick();
      check($sformatf("vec%0d_rule_id", i), 64'(rule_id), 64'(vec[i].e_rule));
      check($sformatf("vec%0d_data_valid", i), 64'(data_valid_out), 64'(vec[i].e_dv));
      check($sformatf("vec%0d_action_valid", i), 64'(action_valid), 64'(vec[i].e_av));
      check($sformatf("vec%0d_win_pipe", i), 64'(win_pipe), 64'(vec[i].e_win));
      check($sformatf("vec%0d_align_err", i), 64'(align_err), 64'd0);
    end

    // Streaming: a new vector every cycle, each result exactly two edges later
    for (int i = 0; i < 8; i++) begin
      drive(i % 5);
      tick();
      if (i >= 1)
        check($sformatf("stream%0d", i), 64'(outs()), 64'(exp_of((i - 1) % 5)));
    end
    drive(4);
    tick(); tick();

    // Misalignment: lane0 pipe2 invalid while the others are valid
    rule_in = '0; act_valid_in = '0; data_valid_in = 8'h0B;
    tick();
    check("align_not_yet", 64'(align_err), 64'd0);
    data_valid_in = 8'h00;
    tick();
    check("align_set", 64'(align_err), 64'd1);
    tick(); tick(); tick();
    check("align_held", 64'(align_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("align_cleared", 64'(align_err), 64'd0);
    // A set and a clear landing on the same edge leave the flag set
    data_valid_in = 8'hD0;
    tick();
    data_valid_in = 8'h00;
    err_clr = 1'b1;
    tick();
    check("align_set_beats_clr", 64'(align_err), 64'd1);
    tick();
    err_clr = 1'b0;
    check("align_clear_after", 64'(align_err), 64'd0);
    tick(); tick();

    // 100 back-to-back valid cycles on both lanes, with a reset at cycle 50
    begin
      int s1e;
      int oute;
      s1e = -1; oute = -1;
      for (int i = 0; i < 100; i++) begin
        drive(pat[i % 3]);
        @(posedge clk);
        if (RST) begin
          s1e = -1; oute = -1;
        end else begin
          oute = s1e; s1e = pat[i % 3];
        end
        #1;
        check($sformatf("b2b%0d", i), 64'(outs()), 64'(exp_of(oute)));
        if (i == 49) begin
          RST = 1'b1;
          #1;
          check("async_reset_outputs", 64'(outs()), 64'd0);
          check("async_reset_align", 64'(align_err), 64'd0);
          s1e = -1; oute = -1;
        end
        if (i == 51) RST = 1'b0;
      end
    end

    // Statistics: 20 hits on lane 1 only, starting from a fresh reset
    drive(4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(2);
      tick();
    end
    drive(4);
    tick(); tick();
    stat_sel = 1'b1;
    #1;
`ifdef MBIT_MERGE_STATS_EN
    check("lane1_hit_cnt_sat", 64'(hit_cnt), 64'd15);
`else
    check("lane1_hit_cnt_tied", 64'(hit_cnt), 64'd0);
`endif
    check("lane1_miss_cnt", 64'(miss_cnt), 64'd0);
    stat_sel = 1'b0;
    #1;
    check("lane0_hit_cnt", 64'(hit_cnt), 64'd0);
    check("lane0_miss_cnt", 64'(miss_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog that bounds the run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
